// File: rtl/alu_step_ctrl_if.sv
// Load-strobe and status bundle between the step sequencer (master) and the
// A/B/F capture registers plus status LEDs (slave).
interface alu_step_ctrl_if;
    logic       ld_a;
    logic       ld_b;
    logic       ld_f;
    logic [3:0] op_q;
    logic [2:0] phase;
    logic [7:0] op_count;

    modport master (output ld_a, ld_b, ld_f, op_q, phase, op_count);
    modport slave  (input  ld_a, ld_b, ld_f, op_q, phase, op_count);
endinterface

// File: rtl/alu_step_ctrl.sv
// Operand/execute sequencer: debounces next/back buttons and walks
// load A -> load B -> latch opcode -> execute, issuing one-cycle load strobes.
module alu_step_ctrl #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next,
    input  logic              btn_back,
    input  logic [3:0]        sw_op,
    alu_step_ctrl_if.master   ctl
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_back, btn_next};

    // Index 0 is "next", index 1 is "back"; both get the same front end.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic          sync1_q, sync2_q;
            logic          deb_q, deb_d;
            logic          deb_dly_q;
            logic          press_q, press_d;
            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                deb_d = deb_q;
                cnt_d = cnt_q;
                if (sync2_q == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    deb_d = sync2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Rising edge of the debounced level, one cycle after it settles.
            assign press_d = deb_q & ~deb_dly_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    deb_q     <= 1'b0;
                    deb_dly_q <= 1'b0;
                    press_q   <= 1'b0;
                    cnt_q     <= '0;
                end else begin
                    sync1_q   <= btn_raw[gi];
                    sync2_q   <= sync1_q;
                    deb_q     <= deb_d;
                    deb_dly_q <= deb_q;
                    press_q   <= press_d;
                    cnt_q     <= cnt_d;
                end
            end

            assign press[gi] = press_q;
        end
    endgenerate

    state_t     state_q, state_d;
    logic       ld_a_q, ld_a_d;
    logic       ld_b_q, ld_b_d;
    logic       ld_f_q, ld_f_d;
    logic [3:0] opcode_q, opcode_d;
    logic [7:0] op_count_q, op_count_d;

    always_comb begin
        state_d    = state_q;
        ld_a_d     = 1'b0;
        ld_b_d     = 1'b0;
        ld_f_d     = 1'b0;
        opcode_d   = opcode_q;
        op_count_d = op_count_q;
        if (press[1]) begin
            state_d = S_A;
        end else begin
            case (state_q)
                S_A: if (press[0]) begin
                    state_d = S_B;
                    ld_a_d  = 1'b1;
                end
                S_B: if (press[0]) begin
                    state_d = S_OP;
                    ld_b_d  = 1'b1;
                end
                S_OP: if (press[0]) begin
                    state_d  = S_EXEC;
                    opcode_d = sw_op;
                end
                // The ALU has seen the new opcode for a full cycle by now.
                S_EXEC: begin
                    state_d    = S_SHOW;
                    ld_f_d     = 1'b1;
                    op_count_d = op_count_q + 8'd1;
                end
                S_SHOW: if (press[0]) begin
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_A;
            ld_a_q     <= 1'b0;
            ld_b_q     <= 1'b0;
            ld_f_q     <= 1'b0;
            opcode_q   <= 4'd0;
            op_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            ld_a_q     <= ld_a_d;
            ld_b_q     <= ld_b_d;
            ld_f_q     <= ld_f_d;
            opcode_q   <= opcode_d;
            op_count_q <= op_count_d;
        end
    end

    assign ctl.ld_a     = ld_a_q;
    assign ctl.ld_b     = ld_b_q;
    assign ctl.ld_f     = ld_f_q;
    assign ctl.op_q     = opcode_q;
    assign ctl.phase    = state_q;
    assign ctl.op_count = op_count_q;
endmodule
